// File: rtl/md5_report_pkg.sv
// rtl/md5_report_pkg.sv - shared constants, enums and helpers for the MD5 result reporter
package md5_report_pkg;

    // ASCII characters used by the two report messages
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_N     = 8'h4E;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Message lengths in bytes
    localparam logic [3:0] FOUND_LEN = 4'd12;
    localparam logic [3:0] DONE_LEN  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FINISH
    } seq_state_e;

    typedef enum logic {
        MSG_FOUND,
        MSG_DONE
    } msg_sel_e;

    // Uppercase hex digit for one nibble
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/md5_result_reporter_if.sv
// rtl/md5_result_reporter_if.sv - search-status inputs and UART report outputs of the reporter
//
// enabled       search-enabled level; rising edge rearms the reporter
// status_found  level, high while the driver holds a match
// status_done   level, high when the search space is exhausted
// found_value   matching candidate, valid while status_found is high
// uart_tx       serial line, idles high
// busy          high while a report is being transmitted
// tx_done       one-cycle pulse after the last stop bit of a report
interface md5_result_reporter_if;
    logic        enabled;
    logic        status_found;
    logic        status_done;
    logic [31:0] found_value;
    logic        uart_tx;
    logic        busy;
    logic        tx_done;

    // Search driver side
    modport master (
        output enabled,
        output status_found,
        output status_done,
        output found_value,
        input  uart_tx,
        input  busy,
        input  tx_done
    );

    // Reporter side
    modport slave (
        input  enabled,
        input  status_found,
        input  status_done,
        input  found_value,
        output uart_tx,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 UART byte transmitter with gap-free back-to-back handshake
//
// CLK         system clock, rising edge
// CPU_RESETN  asynchronous active-low reset
// data        byte to send, taken when valid && ready
// valid       byte offered by the sequencer
// ready       high while idle and during the final cycle of a stop bit
// tx          serial output, idles high
// active      high while a frame is on the line
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       CPU_RESETN,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       active
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [9:0]    shift_q,  shift_d;
    logic [3:0]    bit_q,    bit_d;
    logic [CW-1:0] baud_q,   baud_d;
    logic          last_cycle;

    // Last cycle of the stop bit: a new byte accepted here starts its start
    // bit on the very next cycle, so consecutive frames abut.
    assign last_cycle = active_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
    assign ready      = !active_q || last_cycle;
    assign tx         = active_q ? shift_q[0] : 1'b1;
    assign active     = active_q;

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bit_q    <= '0;
            baud_q   <= '0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
        end
    end

    always_comb begin
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        if (valid && ready) begin
            // Frame is {stop, data, start}, shifted out LSB first
            active_d = 1'b1;
            shift_d  = {1'b1, data, 1'b0};
            bit_d    = 4'd0;
            baud_d   = '0;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/md5_result_reporter.sv
// rtl/md5_result_reporter.sv - reports the MD5 search outcome as an ASCII line over UART
//
// CLK         system clock, all logic on rising edge
// CPU_RESETN  asynchronous active-low reset
// rpt         search status inputs and UART/busy/tx_done outputs (slave side)
module md5_result_reporter
    import md5_report_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200
) (
    input  logic                  CLK,
    input  logic                  CPU_RESETN,
    md5_result_reporter_if.slave  rpt
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    seq_state_e  state_q, state_d;
    msg_sel_e    msg_q,   msg_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  idx_q,   idx_d;
    logic [7:0]  byte_q,  byte_d;
    logic        armed_q, armed_d;
    logic        done_q,  done_d;

    logic prev_found_q, prev_done_q, prev_en_q;
    logic found_rise, done_rise, en_rise;
    logic start;
    logic [3:0] last_idx;

    logic tx_valid, tx_ready, tx_line, tx_active;

    assign found_rise = rpt.status_found && !prev_found_q;
    assign done_rise  = rpt.status_done  && !prev_done_q;
    assign en_rise    = rpt.enabled      && !prev_en_q;

    // Edges are only acted on from IDLE; anything seen mid-report is dropped.
    assign start    = (state_q == ST_IDLE) && armed_q && (found_rise || done_rise);
    assign last_idx = (msg_q == MSG_FOUND) ? (FOUND_LEN - 4'd1) : (DONE_LEN - 4'd1);

    function automatic logic [7:0] msg_byte(input msg_sel_e sel, input logic [3:0] idx,
                                            input logic [31:0] value);
        logic [31:0] sh;
        sh = value >> {(4'd9 - idx), 2'b00};
        if (sel == MSG_FOUND) begin
            case (idx)
                4'd0:    return ASCII_F;
                4'd1:    return ASCII_COLON;
                4'd10:   return ASCII_CR;
                4'd11:   return ASCII_LF;
                default: return nibble_to_ascii(sh[3:0]);
            endcase
        end
        case (idx)
            4'd0:    return ASCII_D;
            4'd1:    return ASCII_COLON;
            4'd2:    return ASCII_N;
            4'd3:    return ASCII_O;
            4'd4:    return ASCII_N;
            4'd5:    return ASCII_E;
            4'd6:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    // State register
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The trigger cycle loads byte 0 itself so the first
    // start bit leaves one cycle after the edge; LOAD fetches each later byte
    // while the previous one is still shifting out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SEND;
            ST_LOAD:   state_d = ST_SEND;
            ST_SEND:   if (tx_ready) state_d = (idx_q < last_idx) ? ST_LOAD : ST_FINISH;
            ST_FINISH: if (tx_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tx_valid = (state_q == ST_SEND);
        done_d   = (state_q == ST_FINISH) && tx_ready;
    end

    // Datapath: edge registers, arming, latched message and byte index
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            prev_found_q <= 1'b0;
            prev_done_q  <= 1'b0;
            prev_en_q    <= 1'b0;
            msg_q        <= MSG_FOUND;
            value_q      <= '0;
            idx_q        <= '0;
            byte_q       <= '0;
            armed_q      <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            prev_found_q <= rpt.status_found;
            prev_done_q  <= rpt.status_done;
            prev_en_q    <= rpt.enabled;
            msg_q        <= msg_d;
            value_q      <= value_d;
            idx_q        <= idx_d;
            byte_q       <= byte_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        msg_d   = msg_q;
        value_d = value_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        armed_d = armed_q;
        if (en_rise) begin
            armed_d = 1'b1;
        end
        if (start) begin
            // Starting consumes the arming; FOUND takes priority over DONE
            armed_d = 1'b0;
            idx_d   = 4'd0;
            if (found_rise) begin
                msg_d   = MSG_FOUND;
                value_d = rpt.found_value;
                byte_d  = ASCII_F;
            end else begin
                msg_d  = MSG_DONE;
                byte_d = ASCII_D;
            end
        end
        if ((state_q == ST_SEND) && tx_ready && (idx_q < last_idx)) begin
            idx_d = idx_q + 4'd1;
        end
        if (state_q == ST_LOAD) begin
            byte_d = msg_byte(msg_q, idx_q, value_q);
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .CLK        (CLK),
        .CPU_RESETN (CPU_RESETN),
        .data       (byte_q),
        .valid      (tx_valid),
        .ready      (tx_ready),
        .tx         (tx_line),
        .active     (tx_active)
    );

    assign rpt.uart_tx = tx_line;
    assign rpt.busy    = tx_active;
    assign rpt.tx_done = done_q;

endmodule

// File: tb/tb_md5_result_reporter.sv
// tb/tb_md5_result_reporter.sv - directed self-checking bench for md5_result_reporter
module tb_md5_result_reporter;

    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md5_result_reporter_if rif();

    md5_result_reporter #(
        .CLK_FREQ_HZ (1000),
        .BAUD        (250)
    ) dut (
        .CLK        (clk),
        .CPU_RESETN (rst_n),
        .rpt        (rif)
    );

    int total    = 0;
    int bad      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    logic [7:0] m_f200  [12] = '{8'h46, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30,
                                 8'h30, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] m_f1234 [12] = '{8'h46, 8'h3A, 8'h31, 8'h32, 8'h33, 8'h34,
                                 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    logic [7:0] m_dead  [12] = '{8'h46, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44,
                                 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] m_done  [12] = '{8'h44, 8'h3A, 8'h4E, 8'h4F, 8'h4E, 8'h45,
                                 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};

    always @(negedge clk) begin
        if (rif.busy === 1'b1)    busy_cnt++;
        if (rif.tx_done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int limit);
        int n = 0;
        while (rif.uart_tx !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " start seen"}, 32'((n < limit) ? 1 : 0), 32'd1);
    endtask

    // Called at the first negedge inside the first start bit
    task automatic recv_msg(input string tag, input int len, input logic [7:0] exp [12]);
        int ferr = 0;
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (rif.uart_tx !== 1'b0) ferr++;
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                b[j] = rif.uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (rif.uart_tx !== 1'b1) ferr++;
            repeat (CPB) @(negedge clk);
            check_eq($sformatf("%s byte%0d", tag, i), {24'd0, b}, {24'd0, exp[i]});
        end
        check_eq({tag, " framing"}, 32'(ferr), 32'd0);
        check_eq({tag, " tx_done at end"}, 32'(rif.tx_done), 32'd1);
        check_eq({tag, " busy low at end"}, 32'(rif.busy), 32'd0);
        check_eq({tag, " line idle at end"}, 32'(rif.uart_tx), 32'd1);
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int act = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (rif.uart_tx !== 1'b1 || rif.busy !== 1'b0) act++;
        end
        check_eq(tag, 32'(act), 32'd0);
    endtask

    task automatic rearm();
        rif.enabled = 1'b0;
        repeat (2) @(negedge clk);
        rif.enabled = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rif.enabled      = 1'b0;
        rif.status_found = 1'b0;
        rif.status_done  = 1'b0;
        rif.found_value  = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset uart_tx", 32'(rif.uart_tx), 32'd1);
        check_eq("reset busy",    32'(rif.busy),    32'd0);
        check_eq("reset tx_done", 32'(rif.tx_done), 32'd0);
        rst_n = 1'b1;

        // Report 1: FOUND 00000200, value changes mid-report
        @(negedge clk);
        rif.enabled = 1'b1;
        repeat (2) @(negedge clk);
        rif.found_value  = 32'h00000200;
        busy_cnt = 0;
        done_cnt = 0;
        rif.status_found = 1'b1;
        @(negedge clk);
        check_eq("t1 line high at trigger", 32'(rif.uart_tx), 32'd1);
        check_eq("t1 busy low at trigger",  32'(rif.busy),    32'd0);
        @(negedge clk);
        check_eq("t1 start bit next cycle", 32'(rif.uart_tx), 32'd0);
        check_eq("t1 busy next cycle",      32'(rif.busy),    32'd1);
        fork
            begin
                repeat (100) @(negedge clk);
                rif.found_value = 32'h12345678;
            end
        join_none
        recv_msg("t1", 12, m_f200);
        check_eq("t1 busy cycles", 32'(busy_cnt), 32'd480);
        repeat (3) @(negedge clk);
        check_eq("t1 tx_done count", 32'(done_cnt), 32'd1);

        // Disarmed: found toggle without re-enable is ignored
        rif.status_found = 1'b0;
        repeat (3) @(negedge clk);
        rif.status_found = 1'b1;
        idle_watch("t4 disarmed no report", 150);
        rif.status_found = 1'b0;
        rearm();
        busy_cnt = 0;
        done_cnt = 0;
        rif.status_found = 1'b1;
        wait_start("t4", 10);
        recv_msg("t4", 12, m_f1234);
        check_eq("t4 busy cycles", 32'(busy_cnt), 32'd480);
        repeat (3) @(negedge clk);
        check_eq("t4 tx_done count", 32'(done_cnt), 32'd1);

        // DONE report
        rif.status_found = 1'b0;
        rearm();
        busy_cnt = 0;
        done_cnt = 0;
        rif.status_done = 1'b1;
        wait_start("t2", 10);
        recv_msg("t2", 8, m_done);
        check_eq("t2 busy cycles", 32'(busy_cnt), 32'd320);
        repeat (3) @(negedge clk);
        check_eq("t2 tx_done count", 32'(done_cnt), 32'd1);

        // Simultaneous found and done: FOUND only
        rif.status_done = 1'b0;
        rearm();
        rif.found_value = 32'hDEADBEEF;
        busy_cnt = 0;
        done_cnt = 0;
        rif.status_found = 1'b1;
        rif.status_done  = 1'b1;
        wait_start("t3", 10);
        recv_msg("t3", 12, m_dead);
        idle_watch("t3 no done report follows", 200);
        check_eq("t3 busy cycles",   32'(busy_cnt), 32'd480);
        check_eq("t3 tx_done count", 32'(done_cnt), 32'd1);

        // Reset in the middle of byte 3, then the report repeats
        rif.status_found = 1'b0;
        rif.status_done  = 1'b0;
        rearm();
        rif.found_value = 32'h00000200;
        busy_cnt = 0;
        done_cnt = 0;
        rif.status_found = 1'b1;
        wait_start("t6", 10);
        repeat (3 * 10 * CPB + 15) @(negedge clk);
        check_eq("t6 busy before reset", 32'(rif.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6 async uart_tx", 32'(rif.uart_tx), 32'd1);
        check_eq("t6 async busy",    32'(rif.busy),    32'd0);
        repeat (5) @(negedge clk);
        check_eq("t6 no tx_done on abort", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        wait_start("t6 rerun", 10);
        recv_msg("t6 rerun", 12, m_f200);
        check_eq("t6 busy cycles", 32'(busy_cnt), 32'd480);
        repeat (3) @(negedge clk);
        check_eq("t6 tx_done count", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
